// File: rtl/shift_sequencer_if.sv
// Request/grant/result bundle between two requesters and the shift sequencer.
interface shift_sequencer_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AMT_W = 5
);
   logic             req0;
   logic [1:0]       op0;
   logic [WIDTH-1:0] Rin0;
   logic [AMT_W-1:0] n0;
   logic             req1;
   logic [1:0]       op1;
   logic [WIDTH-1:0] Rin1;
   logic [AMT_W-1:0] n1;
   logic             gnt0;
   logic             gnt1;
   logic             busy;
   logic             done;
   logic             done_id;
   logic [WIDTH-1:0] Rx;

   modport master (
      output req0, op0, Rin0, n0, req1, op1, Rin1, n1,
      input  gnt0, gnt1, busy, done, done_id, Rx
   );

   modport slave (
      input  req0, op0, Rin0, n0, req1, op1, Rin1, n1,
      output gnt0, gnt1, busy, done, done_id, Rx
   );
endinterface

// File: rtl/shift_sequencer.sv
// Two-requester, round-robin arbitrated shift/rotate engine that performs one
// 1-bit step per cycle; all outputs are registered.
module shift_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AMT_W = 5
) (
   input logic             clk,
   input logic             rst,
   shift_sequencer_if.slave bus
);

   localparam logic [1:0] OP_ROR = 2'b00;
   localparam logic [1:0] OP_ROL = 2'b01;
   localparam logic [1:0] OP_LSR = 2'b10;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] w_q, w_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic             id_q, id_d;
   logic             last_id_q, last_id_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             done_id_q, done_id_d;
   logic [WIDTH-1:0] rx_q, rx_d;

   logic             win;
   logic [1:0]       cap_op;
   logic [WIDTH-1:0] cap_rin;
   logic [AMT_W-1:0] cap_n;
   logic [WIDTH-1:0] stepped;

   function automatic logic [WIDTH-1:0] step(input logic [1:0] op,
                                             input logic [WIDTH-1:0] w);
      case (op)
         OP_ROR:  step = {w[0], w[WIDTH-1:1]};
         OP_ROL:  step = {w[WIDTH-2:0], w[WIDTH-1]};
         OP_LSR:  step = {1'b0, w[WIDTH-1:1]};
         default: step = {w[WIDTH-2:0], 1'b0};
      endcase
   endfunction

   // State and registered outputs; reset discards any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         w_q       <= '0;
         cnt_q     <= '0;
         op_q      <= '0;
         id_q      <= 1'b0;
         last_id_q <= 1'b1;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         rx_q      <= '0;
      end else begin
         state_q   <= state_d;
         w_q       <= w_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         id_q      <= id_d;
         last_id_q <= last_id_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         rx_q      <= rx_d;
      end
   end

   // Next-state and next-output logic; outputs are produced one edge early
   // so the registered versions line up with the state they describe.
   always_comb begin
      state_d   = state_q;
      w_d       = w_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      id_d      = id_q;
      last_id_d = last_id_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      rx_d      = rx_q;

      win     = (bus.req0 && bus.req1) ? ~last_id_q : bus.req1;
      cap_op  = win ? bus.op1  : bus.op0;
      cap_rin = win ? bus.Rin1 : bus.Rin0;
      cap_n   = win ? bus.n1   : bus.n0;
      stepped = step(op_q, w_q);

      case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               op_d      = cap_op;
               w_d       = cap_rin;
               cnt_d     = cap_n;
               id_d      = win;
               last_id_d = win;
               gnt0_d    = ~win;
               gnt1_d    = win;
               if (cap_n == '0) begin
                  state_d   = DONE;
                  done_d    = 1'b1;
                  done_id_d = win;
                  rx_d      = cap_rin;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            w_d   = stepped;
            cnt_d = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
               state_d   = DONE;
               done_d    = 1'b1;
               done_id_d = id_q;
               rx_d      = stepped;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign bus.gnt0    = gnt0_q;
   assign bus.gnt1    = gnt1_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;
   assign bus.Rx      = rx_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer: latency, results,
// arbitration and reset behaviour against hand-computed values.
module tb_shift_sequencer;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned AMT_W = 5;
   localparam logic [1:0] ROR = 2'b00;
   localparam logic [1:0] ROL = 2'b01;
   localparam logic [1:0] LSR = 2'b10;
   localparam logic [1:0] LSL = 2'b11;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

   shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One operation from a single requester: grant, latency, result, id.
   task automatic do_op(input logic id, input logic [1:0] op, input logic [31:0] rin,
                        input logic [4:0] n, input logic [31:0] exp_rx, input string tag);
      int c;
      @(negedge clk);
      if (id) begin
         bus.req1 = 1'b1; bus.op1 = op; bus.Rin1 = rin; bus.n1 = n;
      end else begin
         bus.req0 = 1'b1; bus.op0 = op; bus.Rin0 = rin; bus.n0 = n;
      end
      @(negedge clk);
      chk({tag, "_gnt"}, 32'(id ? bus.gnt1 : bus.gnt0), 32'd1);
      chk({tag, "_gnt_other"}, 32'(id ? bus.gnt0 : bus.gnt1), 32'd0);
      // Drop the request and disturb operands; the captured copy must be used.
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.Rin0 = ~rin; bus.Rin1 = ~rin; bus.op0 = ~op; bus.op1 = ~op;
      bus.n0 = 5'd7; bus.n1 = 5'd7;
      c = 1;
      while (!bus.done && c < 100) begin
         @(negedge clk);
         c++;
      end
      chk({tag, "_latency"}, 32'(c), 32'(n) + 32'd1);
      chk({tag, "_rx"}, bus.Rx, exp_rx);
      chk({tag, "_done_id"}, 32'(bus.done_id), 32'(id));
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
   endtask

   initial begin
      int c;
      int seen;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.req0 = 1'b0; bus.op0 = '0; bus.Rin0 = '0; bus.n0 = '0;
      bus.req1 = 1'b0; bus.op1 = '0; bus.Rin1 = '0; bus.n1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
      chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_done_id", 32'(bus.done_id), 32'd0);
      chk("rst_rx", bus.Rx, 32'h0);
      rst = 1'b0;

      do_op(1'b0, ROR, 32'h00000001, 5'd1,  32'h80000000, "ror1");
      do_op(1'b1, ROL, 32'h80000001, 5'd4,  32'h00000018, "rol4");
      do_op(1'b0, LSL, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, "n0");
      do_op(1'b1, LSR, 32'hF0000000, 5'd31, 32'h00000001, "lsr31");
      do_op(1'b0, LSL, 32'h00000003, 5'd31, 32'h80000000, "lsl31");
      do_op(1'b1, ROR, 32'h12345678, 5'd8,  32'h78123456, "ror8");
      do_op(1'b0, LSR, 32'h0000FFFF, 5'd4,  32'h00000FFF, "lsr4");

      // Both requesters held after reset: 0 first, then 1.
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      bus.req0 = 1'b1; bus.op0 = ROR; bus.Rin0 = 32'h00000001; bus.n0 = 5'd1;
      bus.req1 = 1'b1; bus.op1 = ROL; bus.Rin1 = 32'h80000001; bus.n1 = 5'd4;
      @(negedge clk);
      chk("rr_gnt0", 32'(bus.gnt0), 32'd1);
      chk("rr_gnt1_lo", 32'(bus.gnt1), 32'd0);
      @(negedge clk);
      chk("rr_done0", 32'(bus.done), 32'd1);
      chk("rr_done_id0", 32'(bus.done_id), 32'd0);
      chk("rr_rx0", bus.Rx, 32'h80000000);
      chk("rr_gnt1_busy", 32'(bus.gnt1), 32'd0);
      @(negedge clk);
      chk("rr_idle_busy", 32'(bus.busy), 32'd0);
      chk("rr_idle_gnt1", 32'(bus.gnt1), 32'd0);
      @(negedge clk);
      chk("rr_gnt1", 32'(bus.gnt1), 32'd1);
      chk("rr_gnt0_lo", 32'(bus.gnt0), 32'd0);
      chk("rr_busy1", 32'(bus.busy), 32'd1);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      c = 1;
      while (!bus.done && c < 100) begin
         @(negedge clk);
         c++;
      end
      chk("rr_latency1", 32'(c), 32'd5);
      chk("rr_done_id1", 32'(bus.done_id), 32'd1);
      chk("rr_rx1", bus.Rx, 32'h00000018);
      @(negedge clk);
      chk("rr_end_busy", 32'(bus.busy), 32'd0);

      // Reset in the middle of an n=10 operation.
      bus.req0 = 1'b1; bus.op0 = LSL; bus.Rin0 = 32'h00000001; bus.n0 = 5'd10;
      @(negedge clk);
      chk("mid_gnt0", 32'(bus.gnt0), 32'd1);
      bus.req0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_busy", 32'(bus.busy), 32'd0);
      chk("mid_rx", bus.Rx, 32'h0);
      chk("mid_done", 32'(bus.done), 32'd0);
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      chk("mid_no_done", 32'(seen), 32'd0);
      do_op(1'b0, LSL, 32'h00000001, 5'd10, 32'h00000400, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, datapath width in bits.
REQ-002 Parameter: AMT_W, 5, shift-amount width in bits; 2^AMT_W equals WIDTH.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req0  input  1  requester 0 operation request; held high until gnt0 is seen.
REQ-006 Port: op0  input  2  requester 0 opcode: 00 ROR, 01 ROL, 10 LSR, 11 LSL.
REQ-007 Port: Rin0  input  WIDTH  requester 0 operand.
REQ-008 Port: n0  input  AMT_W  requester 0 shift/rotate amount, 0..WIDTH-1.
REQ-009 Port: req1, op1, Rin1, n1  input  1/2/WIDTH/AMT_W  requester 1 equivalents of REQ-005 to REQ-008.
REQ-010 Port: gnt0, gnt1  output  1 each  one-cycle grant pulse to the accepted requester.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.
REQ-012 Port: done  output  1  one-cycle pulse; Rx valid.
REQ-013 Port: done_id  output  1  index of the requester whose result is on Rx.
REQ-014 Port: Rx  output  WIDTH  result register; holds its value until the next done.

Function
REQ-015 States: IDLE, SHIFT and DONE; SHALL be encoded in a registered state variable.
REQ-016 IDLE: on an edge with req0 or req1 high, the block captures the winner's op, Rin, n and id into internal registers.
- Next state is SHIFT if the captured n is nonzero.
- Next state is DONE if the captured n is 0.
REQ-017 The gnt of the winner SHALL be high only in the cycle immediately after the capture edge; both gnts are never high together.
REQ-018 Arbitration: round-robin on a last_id register.
- With a single requester, that requester wins.
- With both requesting, the requester not equal to last_id wins.
- last_id updates on every capture.
REQ-019 Requests SHALL be ignored while busy=1. A requester still high after its gnt pulse is not re-captured until state returns to IDLE.
REQ-020 SHIFT: each cycle, the working register is updated by exactly one 1-bit step of the captured op, and a down-counter loaded with n decrements. The transition to DONE follows the step where the counter reaches 0, so SHIFT lasts exactly n cycles.
REQ-021 1-bit steps:
- ROR = {w[0], w[WIDTH-1:1]}
- ROL = {w[WIDTH-2:0], w[WIDTH-1]}
- LSR = {1'b0, w[WIDTH-1:1]}
- LSL = {w[WIDTH-2:0], 1'b0}
REQ-022 DONE lasts one cycle. Rx carries the working register and done_id the captured id, with done=1. The next state is always IDLE.
REQ-023 Latency: with capture at edge k, done SHALL be high in cycle k+n+1; for n=0 that is cycle k+1, with Rx equal to the captured Rin.
REQ-024 Throughput: a new capture is possible at the edge ending DONE+1, i.e. in the first IDLE cycle; back-to-back operations are never overlapped.
REQ-025 Operand inputs SHALL be sampled only at the capture edge; later changes have no effect on the operation in progress.

Reset
REQ-026 With rst high at an edge: state=IDLE, gnt0=gnt1=0, busy=0, done=0, done_id=0, Rx=0, counter=0, last_id=1, so requester 0 wins the first tie.
REQ-027 rst takes priority over every other event, including a simultaneous request, SHIFT step or DONE. An operation in flight is discarded with no done pulse.

Verification
REQ-028 Rin0=0x00000001, op0=ROR, n0=1, req0 only -> gnt0 at k+1, done at k+2, Rx=0x80000000, done_id=0.
REQ-029 Rin1=0x80000001, op1=ROL, n1=4 -> done at k+5, Rx=0x00000018, done_id=1.
REQ-030 Rin0=0xDEADBEEF, n0=0, any op -> no SHIFT cycle, done at k+1, Rx=0xDEADBEEF.
REQ-031 After reset, req0 and req1 both high and held -> gnt0 first, then gnt1 after the first done; done_id sequence 0 then 1; busy low for exactly one cycle between operations.
REQ-032 LSR on 0xF0000000 with n=31 -> Rx=0x00000001; LSL on 0x00000003 with n=31 -> Rx=0x80000000; each done at k+32.
REQ-033 rst pulsed at cycle k+3 of an n=10 operation -> following cycle: busy=0, Rx=0, no done pulse; a new req0 is accepted normally afterwards.
